mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for mem_ack before an access is aborted (legal range 2..255).
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  32  access address, driven by the instruction/data address select mux (PC or ALUOut).
REQ-006 start  input  1  one-cycle access request from the main control FSM.
REQ-007 we  input  1  1 = write access, 0 = read access; sampled with start.
REQ-008 ir_write  input  1  read result goes to ir when 1 and to mdr when 0; sampled with start.
REQ-009 wdata  input  32  write data; sampled with start.
REQ-010 mem_req / mem_we  output  1 each  memory bus request / write strobe.
REQ-011 mem_addr / mem_wdata  output  32 each  memory bus address / write data.
REQ-012 mem_rdata  input  32  memory read data; valid in the cycle mem_ack is high.
REQ-013 mem_ack  input  1  memory completion; valid only while mem_req is high.
REQ-014 ir / mdr  output  32 each  instruction register / memory data register.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err_misalign / err_timeout  output  1 each  error flags for the last access.

Function
REQ-018 The FSM SHALL use exactly the states IDLE, ACCESS and DONE.
REQ-019 IDLE: start=1 with addr[1:0]==0 SHALL latch addr, we, ir_write and wdata, and go to ACCESS.
REQ-020 IDLE: start=1 with addr[1:0]!=0 SHALL set err_misalign, issue no bus request, and go to DONE.
REQ-021 ACCESS: mem_req SHALL be 1, and mem_addr, mem_we and mem_wdata SHALL hold the latched values, stable until the access ends.
REQ-022 ACCESS: mem_ack=1 SHALL end the access, go to DONE, and deassert mem_req on the next cycle.
REQ-023 On an acked read, mem_rdata SHALL load ir if ir_write was latched as 1, otherwise mdr; the other register SHALL be unchanged.
REQ-024 An acked write SHALL leave both ir and mdr unchanged.
REQ-025 Timeout: a cycle counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack.
REQ-026 If the count reaches TIMEOUT-1 without mem_ack, the controller SHALL set err_timeout, drop mem_req, and go to DONE, with ir and mdr unchanged.
REQ-027 mem_ack=1 in the cycle the timeout expires SHALL count as success, not timeout.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Minimum latency: start sampled at edge 0, mem_req high in cycle 1, ack in cycle 1, done and the new ir/mdr value visible in cycle 2.
REQ-030 start while busy=1 SHALL be ignored, with no queuing.
REQ-031 Error flags SHALL be sticky until the next accepted start, which clears both.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 mem_we and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-034 rst_n low SHALL force, asynchronously, state=IDLE, counter=0, and all outputs (mem_req, mem_we, mem_addr, mem_wdata, ir, mdr, busy, done, err_*) to 0.
REQ-035 Reset asserted mid-access SHALL drop mem_req immediately and discard the access.
REQ-036 The first start accepted after rst_n rises SHALL behave exactly as from power-up.

Structure
REQ-037 The shared cpu package SHALL hold the state enumeration (IDLE/ACCESS/DONE), the word width constant (32), and the default TIMEOUT value.
REQ-038 The timeout counter SHALL be one sub-module, timeout_counter, with clear, enable and expired ports.
REQ-039 All other logic SHALL reside in mem_access_ctrl.

Verification
REQ-040 Read into ir: start, addr=0x0000_0040, we=0, ir_write=1, ack in cycle 1 with mem_rdata=0x8C01_0004 -> ir=0x8C01_0004 and done=1 in cycle 2; mdr unchanged.
REQ-041 Write with wait: start, addr=0x0000_1000, we=1, wdata=0xDEAD_BEEF, ack after 3 wait cycles -> mem_we=1, bus fields stable for 4 cycles, then done; ir and mdr unchanged.
REQ-042 Misaligned: start with addr=0x0000_0042 -> mem_req never asserts, done plus err_misalign in cycle 1; the next aligned start clears err_misalign.
REQ-043 Timeout: TIMEOUT=16, mem_ack held 0 -> mem_req high for exactly 16 cycles, then err_timeout and done; ack in the 16th cycle instead -> success with no error.
REQ-044 Reset mid-access: rst_n low during ACCESS -> mem_req=0 in the same cycle, all outputs 0; the following read completes normally.
REQ-045 Start while busy: a second start during ACCESS -> ignored, exactly one done pulse, latched address unchanged.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM states, word width
// and the default abort timeout.
package mem_access_ctrl_pkg;
  localparam int WORD_W      = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/mem_access_ctrl_timeout_counter.sv
// Cycle counter for bus wait states; expired flags the last allowed ACCESS cycle.
module timeout_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access controller: one bus access per start, result into
// ir or mdr, with misalignment and ack-timeout detection.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              start,
  input  logic              we,
  input  logic              ir_write,
  input  logic [WORD_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err_misalign,
  output logic              err_timeout
);
  state_e            state_q;
  logic              mem_req_q, mem_we_q, ir_write_q, done_q;
  logic              err_mis_q, err_to_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q, ir_q, mdr_q;
  logic              expired;

  // Counter sits at zero outside ACCESS, so it is clear on every entry.
  timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ACCESS),
    .enable  ((state_q == ACCESS) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ir_write_q  <= 1'b0;
      ir_q        <= '0;
      mdr_q       <= '0;
      done_q      <= 1'b0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          err_mis_q <= 1'b0;
          err_to_q  <= 1'b0;
          if (addr[1:0] != 2'b00) begin
            err_mis_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
            ir_write_q  <= ir_write;
            state_q     <= ACCESS;
          end
        end
        ACCESS: if (mem_ack || expired) begin
          // Ack wins over an expiring timeout in the same cycle.
          if (mem_ack && !mem_we_q) begin
            if (ir_write_q) ir_q  <= mem_rdata;
            else            mdr_q <= mem_rdata;
          end
          if (!mem_ack) err_to_q <= 1'b1;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign ir           = ir_q;
  assign mdr          = mdr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;
endmodule
